// File: rtl/sobel_pkg.sv
// Shared constants and types for the 3x3 Sobel edge detector.
package sobel_pkg;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  // Clocks from an accepted input pixel to its registered output.
  localparam int SOBEL_LAT = 3;

  localparam int PIX_W   = 8;
  // Signed gradient width: each of Gx/Gy spans +/-1020.
  localparam int GRAD_W  = 11;
  // Unsigned |Gx|+|Gy| width: at most 2040.
  localparam int MAG_W   = 11;
  localparam int MAG_SAT = 255;

  typedef logic [PIX_W-1:0] pixel_t;

  // One window column: top is the oldest row (r-2), bot is the current row (r).
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

endpackage

// File: rtl/line_buffer_gray8.sv
// Single-clock simple dual-port line RAM, synchronous read, read-before-write.
module line_buffer_gray8
  import sobel_pkg::*;
#(
  parameter int DEPTH  = IMG_W_DEF,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data
);

  pixel_t mem [DEPTH];

  // Read and write in one block so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_edge_gray8.sv
// Streaming 3x3 Sobel edge detector for 8-bit grayscale, zero border,
// saturated |Gx|+|Gy| magnitude and thresholded edge flag, 3-clock latency.
module sobel_edge_gray8
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  input  logic [7:0] threshold,
  output logic       out_valid,
  output logic [7:0] out_mag,
  output logic       out_edge
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Zero-extend a pixel into the signed gradient domain.
  function automatic logic signed [GRAD_W-1:0] ext_pix(input pixel_t p);
    return signed'({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  // (b0 + 2*b1 + b2) - (a0 + 2*a1 + a2): the shared 1-2-1 difference kernel.
  function automatic logic signed [GRAD_W-1:0] diff_121(
    input pixel_t a0, input pixel_t a1, input pixel_t a2,
    input pixel_t b0, input pixel_t b1, input pixel_t b2
  );
    logic signed [GRAD_W-1:0] pos;
    logic signed [GRAD_W-1:0] neg;
    pos = ext_pix(b0) + (ext_pix(b1) <<< 1) + ext_pix(b2);
    neg = ext_pix(a0) + (ext_pix(a1) <<< 1) + ext_pix(a2);
    return pos - neg;
  endfunction

  // Absolute value of a gradient; -1020 is the most negative value, so no overflow.
  function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] a;
    a = (g < 0) ? -g : g;
    return MAG_W'(unsigned'(a));
  endfunction

  // Clamp the 11-bit magnitude to the 8-bit output range.
  function automatic pixel_t sat_mag(input logic [MAG_W-1:0] m);
    if (m > MAG_W'(MAG_SAT)) begin
      return pixel_t'(MAG_SAT);
    end
    return m[PIX_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Raster position of the incoming pixel. frame_start makes the current pixel (0,0).
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             interior;

  assign cur_col  = frame_start ? '0 : col;
  assign cur_row  = frame_start ? '0 : row;
  // A centre is only defined once two earlier rows and two earlier columns exist.
  assign interior = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

  // Advance col/row per accepted pixel; row sticks at the last line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? cur_row : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end else if (frame_start) begin
      col <= '0;
      row <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers. LB0 holds row r-1, LB1 holds row r-2. LB1 is refilled with
  // what LB0 returned, one clock after the read since the RAM read is registered;
  // that address is not read again until the following line.
  // ---------------------------------------------------------------------------
  pixel_t           lb0_rd;
  pixel_t           lb1_rd;
  pixel_t           pix_p0;
  logic [COL_W-1:0] col_p0;
  logic             vld_p0;
  logic             int_p0;

  line_buffer_gray8 #(
    .DEPTH  (IMG_W),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk     (clk),
    .rd_en   (in_valid),
    .rd_addr (cur_col),
    .rd_data (lb0_rd),
    .wr_en   (in_valid),
    .wr_addr (cur_col),
    .wr_data (in_pixel)
  );

  line_buffer_gray8 #(
    .DEPTH  (IMG_W),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .rd_en   (in_valid),
    .rd_addr (cur_col),
    .rd_data (lb1_rd),
    .wr_en   (vld_p0),
    .wr_addr (col_p0),
    .wr_data (lb0_rd)
  );

  // ---- stage p0: RAM read data, pixel and window shift land together ----
  column_t win_c0;
  column_t win_c1;
  column_t win_c2;

  // Newest column is live: the two RAM outputs plus the pixel captured with them.
  assign win_c2 = '{top: lb1_rd, mid: lb0_rd, bot: pix_p0};

  // Pipeline control for stage p0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      int_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      int_p0 <= in_valid && interior;
    end
  end

  // Pixel and column captured alongside the RAM read.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      pix_p0 <= in_pixel;
      col_p0 <= cur_col;
    end
  end

  // Shift the two older window columns once per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_c0 <= '0;
      win_c1 <= '0;
    end else if (in_valid) begin
      win_c0 <= win_c1;
      win_c1 <= win_c2;
    end
  end

  // ---- stage p1: Gx / Gy ----
  logic signed [GRAD_W-1:0] gx_p1;
  logic signed [GRAD_W-1:0] gy_p1;
  logic                     vld_p1;
  logic                     int_p1;

  // Pipeline control for stage p1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      int_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      int_p1 <= vld_p0 && int_p0;
    end
  end

  // Gx is right column minus left column; Gy is bottom row minus top row.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      gx_p1 <= diff_121(win_c0.top, win_c0.mid, win_c0.bot,
                        win_c2.top, win_c2.mid, win_c2.bot);
      gy_p1 <= diff_121(win_c0.top, win_c1.top, win_c2.top,
                        win_c0.bot, win_c1.bot, win_c2.bot);
    end
  end

  // ---- stage p2: magnitude, saturation, threshold, output ----
  logic [MAG_W-1:0] mag;
  pixel_t           mag_sat;

  assign mag     = abs_grad(gx_p1) + abs_grad(gy_p1);
  assign mag_sat = sat_mag(mag);

  // Border pixels and idle cycles present zero magnitude and no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_edge  <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      out_mag   <= (vld_p1 && int_p1) ? mag_sat : '0;
      out_edge  <= vld_p1 && int_p1 && (mag_sat >= threshold);
    end
  end

endmodule
